pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stall_req  input  1  hazard detected for the instruction in ID.
REQ-004 SHALL have port stall_cycles  input  2  bubbles required: EX-stage match = 3, MEM = 2, WB = 1; value 0 treated as 1.
REQ-005 SHALL have port flush  input  1  taken branch/jump resolved; the instruction in ID is wrong-path.
REQ-006 SHALL have port pc_write  output  1  PC register load enable.
REQ-007 SHALL have port ifid_write  output  1  IF/ID register load enable.
REQ-008 SHALL have port ifid_flush  output  1  clear IF/ID to NOP on next edge.
REQ-009 SHALL have port idex_bubble  output  1  zero the ID/EX control fields (insert NOP) on next edge.
REQ-010 SHALL have port stall_busy  output  1  stall countdown in progress; fed back to the hazard unit's already-stalled input.

Function
REQ-011 SHALL implement two states, IDLE and HOLD, plus a 2-bit down-counter cnt; all outputs are combinational from state, cnt and inputs.
REQ-012 IDLE, no stall_req, no flush: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall_busy=0.
REQ-013 IDLE with stall_req=1 and flush=0: same cycle pc_write=0, ifid_write=0, idex_bubble=1; N = max(stall_cycles,1); cnt loads N-1; next state HOLD if N-1 != 0, otherwise IDLE.
REQ-014 HOLD: pc_write=0, ifid_write=0, idex_bubble=1, stall_busy=1, ifid_flush=0; cnt decrements each cycle; next state IDLE when cnt == 1 at the edge.
REQ-015 Total bubbles per accepted request SHALL equal N exactly; PC and IF/ID SHALL be frozen for exactly N cycles.
REQ-016 stall_req SHALL be ignored while state is HOLD (no reload, no extension).
REQ-017 flush=1 in any state SHALL take priority: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, stall_busy=0; cnt cleared; next state IDLE; a simultaneous stall_req is discarded.
REQ-018 The first IDLE cycle after HOLD SHALL accept a new stall_req normally.

Reset
REQ-019 While reset=1: next state IDLE, cnt=0; outputs pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, stall_busy=0, regardless of other inputs.
REQ-020 reset asserted in HOLD SHALL abort the stall; the cycle after reset deasserts behaves as IDLE per REQ-012/013.

Configuration
REQ-021 Macro STALL_PERF_CNT_EN: when defined, adds port stall_count  output  32, reset to 0, incremented on every cycle with idex_bubble=1 caused by a stall (REQ-013/014, not flush or reset), saturating at 0xFFFFFFFF.
REQ-022 Without STALL_PERF_CNT_EN, port stall_count and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Reset 2 cycles, then idle 3 cycles -> pc_write=ifid_write=1, idex_bubble=0, stall_busy=0 every cycle.
REQ-024 stall_req=1, stall_cycles=3 for one cycle -> idex_bubble=1 for 3 cycles, pc_write=0 for 3 cycles, stall_busy=1 in cycles 2-3 only; stall_count=3.
REQ-025 stall_cycles=0 and stall_cycles=1 requests -> single bubble each, stall_busy never 1, no HOLD entry.
REQ-026 stall_cycles=2, stall_req held high 4 cycles -> bubbles in cycles 1-2, new stall accepted cycle 3, bubbles cycles 3-4; stall_count=4.
REQ-027 stall_cycles=3 accepted, flush=1 in second cycle -> that cycle ifid_flush=1, pc_write=1, stall_busy=0; next cycle IDLE outputs; stall_count=1.
REQ-028 reset=1 in HOLD, then released -> outputs per REQ-019 during reset, IDLE values after; counter (if enabled) 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Purpose : freezes PC and IF/ID and injects ID/EX bubbles for load-use/RAW hazards; flushes wrong-path ID on taken branch.
// Latency : control outputs are combinational from state, countdown and inputs (same-cycle response to stall_req/flush).
// Backpressure: stall_req is accepted only in IDLE; during HOLD further requests are ignored until the countdown ends.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   stall_req    in   hazard detected for the instruction in ID
//   stall_cycles in   [1:0] bubbles required (EX=3, MEM=2, WB=1; 0 behaves as 1)
//   flush        in   taken branch/jump resolved; instruction in ID is wrong-path
//   pc_write     out  PC load enable
//   ifid_write   out  IF/ID load enable
//   ifid_flush   out  clear IF/ID to NOP on next edge
//   idex_bubble  out  zero ID/EX control fields on next edge
//   stall_busy   out  countdown in progress (feeds hazard unit's already-stalled input)
//   stall_count  out  [31:0] saturating count of stall bubbles (only with STALL_PERF_CNT_EN)
//
// Optional feature macro: STALL_PERF_CNT_EN adds the stall_count performance counter.

module pipeline_stall_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_req,
    input  logic [1:0] stall_cycles,
    input  logic       flush,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       stall_busy
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    // Remaining bubbles after the one issued in the accept cycle.
    // A request for 0 bubbles is treated as a request for 1.
    logic [1:0] extra_bubbles;

    // A bubble caused by a hazard (not by flush or reset).
    logic       stall_bubble;

    always_comb begin
        if (stall_cycles == 2'd0) begin
            extra_bubbles = 2'd0;
        end else begin
            extra_bubbles = stall_cycles - 2'd1;
        end
    end

    assign stall_bubble = !reset && !flush &&
                          ((state_q == HOLD) || stall_req);

    // ------------------------------------------------------------------
    // Output decode. Priority: reset, then flush, then HOLD, then a new
    // request in IDLE, then normal flow.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_busy  = 1'b0;

        if (reset) begin
            // Hold the front end and drain NOPs into the pipe while in reset.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (flush) begin
            // Wrong-path instruction in ID: kill it and let the redirected
            // PC load; any pending or simultaneous stall is abandoned.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == HOLD) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_busy  = 1'b1;
        end else if (stall_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and countdown.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (reset || flush) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall_req) begin
                        cnt_d   = extra_bubbles;
                        state_d = (extra_bubbles != 2'd0) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    // cnt_q counts the HOLD cycles still owed including this
                    // one; leaving at 1 makes total frozen cycles exactly N.
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating count of hazard-induced bubbles.
    // ------------------------------------------------------------------
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (stall_bubble && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt_q <= 32'd0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign stall_count = perf_cnt_q;
`else
    // Bubble qualifier only feeds the optional counter.
    logic unused_stall_bubble;
    assign unused_stall_bubble = stall_bubble;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Purpose : directed self-checking bench for pipeline_stall_ctrl.
// Latency : inputs driven at falling edge, combinational outputs sampled 1 time unit later.
// Backpressure: n/a (bench drives every cycle).

module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       reset;
    logic       stall_req;
    logic [1:0] stall_cycles;
    logic       flush;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       stall_busy;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall_req    (stall_req),
        .stall_cycles (stall_cycles),
        .flush        (flush),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .stall_busy   (stall_busy)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, stall_busy}
    localparam logic [4:0] O_RST  = 5'b00110;
    localparam logic [4:0] O_IDLE = 5'b11000;
    localparam logic [4:0] O_ACC  = 5'b00010;
    localparam logic [4:0] O_HOLD = 5'b00011;
    localparam logic [4:0] O_FLSH = 5'b11110;

    // One clock cycle: apply inputs in the low phase, then check outputs.
    task automatic step(input logic r, input logic sr, input logic [1:0] sc,
                        input logic fl, input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        @(negedge clk);
        reset        = r;
        stall_req    = sr;
        stall_cycles = sc;
        flush        = fl;
        #1;
        obs = {pc_write, ifid_write, ifid_flush, idex_bubble, stall_busy};
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef STALL_PERF_CNT_EN
        n_checks++;
        assert (stall_count === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, stall_count, exp);
        end
`else
        if (tag.len() < 0 || exp === 32'hx) begin
            $display("note: stall_count absent in this build");
        end
`endif
    endtask

    initial begin
        reset        = 1'b1;
        stall_req    = 1'b0;
        stall_cycles = 2'd0;
        flush        = 1'b0;

        // Reset two cycles; outputs fixed regardless of other inputs.
        step(1, 0, 2'd0, 0, "rst_c1", O_RST);
        step(1, 1, 2'd3, 0, "rst_c2_stallreq", O_RST);
        step(0, 0, 2'd0, 0, "idle_c1", O_IDLE);
        chk_cnt("rst_cnt", 32'd0);
        step(0, 0, 2'd0, 0, "idle_c2", O_IDLE);
        step(0, 0, 2'd0, 0, "idle_c3", O_IDLE);

        // Three-bubble stall; requests during HOLD are ignored.
        step(0, 1, 2'd3, 0, "s3_c1", O_ACC);
        step(0, 1, 2'd3, 0, "s3_c2", O_HOLD);
        step(0, 0, 2'd1, 0, "s3_c3", O_HOLD);
        step(0, 0, 2'd0, 0, "s3_after", O_IDLE);
        chk_cnt("s3_cnt", 32'd3);

        // Zero and one both give a single bubble with no HOLD.
        step(1, 0, 2'd0, 0, "s0_rst", O_RST);
        step(0, 1, 2'd0, 0, "s0_c1", O_ACC);
        step(0, 0, 2'd0, 0, "s0_after", O_IDLE);
        step(0, 1, 2'd1, 0, "s1_c1", O_ACC);
        step(0, 0, 2'd0, 0, "s1_after", O_IDLE);
        chk_cnt("s01_cnt", 32'd2);

        // Two-bubble stall with request held: back-to-back acceptance.
        step(1, 0, 2'd0, 0, "s2_rst", O_RST);
        step(0, 1, 2'd2, 0, "s2_c1", O_ACC);
        step(0, 1, 2'd2, 0, "s2_c2", O_HOLD);
        step(0, 1, 2'd2, 0, "s2_c3_reaccept", O_ACC);
        step(0, 1, 2'd2, 0, "s2_c4", O_HOLD);
        step(0, 0, 2'd0, 0, "s2_after", O_IDLE);
        chk_cnt("s2_cnt", 32'd4);

        // Flush in HOLD aborts the stall.
        step(1, 0, 2'd0, 0, "fl_rst", O_RST);
        step(0, 1, 2'd3, 0, "fl_c1", O_ACC);
        step(0, 0, 2'd3, 1, "fl_c2_flush", O_FLSH);
        step(0, 0, 2'd0, 0, "fl_c3_idle", O_IDLE);
        chk_cnt("fl_cnt", 32'd1);
        // Flush with simultaneous request in IDLE discards the request.
        step(0, 1, 2'd3, 1, "fl_sim", O_FLSH);
        step(0, 0, 2'd0, 0, "fl_sim_after", O_IDLE);
        chk_cnt("fl_sim_cnt", 32'd1);

        // Reset during HOLD aborts; next request accepted immediately.
        step(0, 1, 2'd3, 0, "rh_c1", O_ACC);
        step(0, 0, 2'd0, 0, "rh_c2", O_HOLD);
        step(1, 0, 2'd0, 0, "rh_rst", O_RST);
        step(0, 0, 2'd0, 0, "rh_idle", O_IDLE);
        chk_cnt("rh_cnt", 32'd0);
        step(0, 1, 2'd1, 0, "rh_new", O_ACC);
        step(0, 0, 2'd0, 0, "rh_new_after", O_IDLE);
        chk_cnt("rh_new_cnt", 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
